// File: rtl/fifo_resolu_pkg.sv
// Shared types and helpers for the FIFO-word resolver/serialiser.
// Helper vectors are VEC_W wide so one function body serves any DATA_W up to VEC_W.
package fifo_resolu_pkg;

  typedef enum logic [1:0] {IDLE, POP, CAP, SEND} resolu_state_e;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_BEAT_W = 16;
  localparam int unsigned MAX_BEATS  = DEF_DATA_W / DEF_BEAT_W;
  localparam int unsigned VEC_W      = 512;

  typedef logic [VEC_W-1:0] vec_t;

  function automatic vec_t bin2gray(input vec_t b);
    return b ^ (b >> 1);
  endfunction

  // Ones over the len*beat_w MSBs of a data_w-bit word, zero elsewhere.
  function automatic vec_t len_to_mask(input int unsigned len, input int unsigned data_w,
                                       input int unsigned beat_w);
    vec_t        m;
    int unsigned lo;
    m  = '0;
    lo = (len * beat_w >= data_w) ? 0 : data_w - len * beat_w;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      m[i] = (i < data_w) && (i >= lo);
    end
    return m;
  endfunction

endpackage

// File: rtl/resolu_mask_gray.sv
// Combinational payload builder: truncates to len_code beats, optionally Gray-codes,
// and flags illegal length codes.
module resolu_mask_gray
  import fifo_resolu_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned BEAT_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  len_code,
  input  logic              gray_mode,
  output logic [DATA_W-1:0] payload,
  output logic              len_ok
);

  localparam int unsigned MaxBeats = DATA_W / BEAT_W;

  vec_t                    mask;
  vec_t                    cut;
  vec_t                    wide;
  logic [VEC_W-1:DATA_W]   unused_wide_hi;

  // Re-applying the mask after Gray coding clears the bit shifted across the cut boundary.
  always_comb begin
    mask              = len_to_mask(32'(len_code), DATA_W, BEAT_W);
    cut               = '0;
    cut[DATA_W-1:0]   = data;
    cut               = cut & mask;
    wide              = gray_mode ? (bin2gray(cut) & mask) : cut;
  end

  assign payload        = wide[DATA_W-1:0];
  assign unused_wide_hi = wide[VEC_W-1:DATA_W];
  assign len_ok         = (len_code != '0) && (32'(len_code) <= MaxBeats);

endmodule

// File: rtl/fifo_data_resolu_ser.sv
// Pops {data, ch_sel, len_code} words from a sync FIFO and streams the masked,
// optionally Gray-coded payload MSB-first as BEAT_W-bit beats on valid/ready.
module fifo_data_resolu_ser
  import fifo_resolu_pkg::*;
#(
  parameter  int unsigned DATA_W = 128,
  parameter  int unsigned CH_W   = 8,
  parameter  int unsigned LEN_W  = 4,
  parameter  int unsigned BEAT_W = 16,
  localparam int unsigned WORD_W = DATA_W + CH_W + LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] data_from_fifo,
  input  logic              gray_mode,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last,
  output logic [15:0]       data_count,
  output logic              len_err,
  output logic              busy
);

  resolu_state_e     state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  nb_q, nb_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              rd_en_q, rd_en_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [15:0]       count_q, count_d;
  logic              len_err_q, len_err_d;
  logic              busy_q;

  logic [DATA_W-1:0] word_data;
  logic [CH_W-1:0]   word_ch;
  logic [LEN_W-1:0]  word_len;
  logic [DATA_W-1:0] payload;
  logic              len_ok;

  assign word_data = data_from_fifo[WORD_W-1 -: DATA_W];
  assign word_ch   = data_from_fifo[CH_W+LEN_W-1 -: CH_W];
  assign word_len  = data_from_fifo[LEN_W-1:0];

  resolu_mask_gray #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .BEAT_W (BEAT_W)
  ) u_mask_gray (
    .data      (word_data),
    .len_code  (word_len),
    .gray_mode (gray_mode),
    .payload   (payload),
    .len_ok    (len_ok)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    nb_d      = nb_q;
    beat_d    = beat_q;
    rd_en_d   = 1'b0;
    valid_d   = valid_q;
    last_d    = last_q;
    ch_d      = ch_q;
    count_d   = count_q;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = POP;
        end
      end
      POP: state_d = CAP;
      CAP: begin
        if (!len_ok) begin
          len_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          shreg_d = payload;
          nb_d    = word_len;
          beat_d  = '0;
          ch_d    = word_ch;
          count_d = 16'(word_len) * 16'(BEAT_W);
          valid_d = 1'b1;
          last_d  = (word_len == LEN_W'(1));
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // The shift register keeps the current beat in its top BEAT_W bits.
            shreg_d = shreg_q << BEAT_W;
            beat_d  = beat_q + LEN_W'(1);
            last_d  = ((beat_q + LEN_W'(2)) == nb_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      nb_q      <= '0;
      beat_q    <= '0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      ch_q      <= '0;
      count_q   <= '0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      nb_q      <= nb_d;
      beat_q    <= beat_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      ch_q      <= ch_d;
      count_q   <= count_d;
      len_err_q <= len_err_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign out_valid  = valid_q;
  assign out_data   = shreg_q[DATA_W-1 -: BEAT_W];
  assign out_last   = last_q;
  assign out_ch     = ch_q;
  assign data_count = count_q;
  assign len_err    = len_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_data_resolu_ser.sv
// Directed bench for fifo_data_resolu_ser with a behavioural 1-cycle-latency FIFO
// and a handshake monitor; expected beats are hand-computed constants.
module tb_fifo_data_resolu_ser;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
    logic [7:0]  ch;
    logic [15:0] cnt;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [139:0] data_from_fifo;
  logic         gray_mode;
  logic         out_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [7:0]   out_ch;
  logic         out_last;
  logic [15:0]  data_count;
  logic         len_err;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [139:0] fifo_q[$];
  beat_t        beats[$];
  int           rd_times[$];
  int           cyc = 0;
  int           rd_cnt = 0;
  int           rd_empty_cnt = 0;
  int           err_cnt = 0;
  int           valid_cnt = 0;

  fifo_data_resolu_ser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .data_from_fifo (data_from_fifo),
    .gray_mode      (gray_mode),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ch         (out_ch),
    .out_last       (out_last),
    .data_count     (data_count),
    .len_err        (len_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync FIFO model: a pop requested in one cycle shows its word the next cycle.
  always @(posedge clk) begin
    if (rst_n && fifo_rd_en && fifo_q.size() != 0) begin
      #1;
      data_from_fifo = fifo_q.pop_front();
      fifo_empty     = (fifo_q.size() == 0);
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) beats.push_back('{out_data, out_last, out_ch, data_count});
      if (fifo_rd_en) begin
        rd_cnt++;
        rd_times.push_back(cyc);
        if (fifo_empty) rd_empty_cnt++;
      end
      if (len_err) err_cnt++;
      if (out_valid) valid_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [127:0] d, input logic [7:0] ch, input logic [3:0] len);
    fifo_q.push_back({d, ch, len});
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain"}, 128'(n < 300), 128'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int i, input logic [15:0] d,
                            input logic last, input logic [7:0] ch, input logic [15:0] cnt);
    if (i < beats.size()) begin
      check($sformatf("%s_b%0d", tag, i), 128'(beats[i]), 128'({d, last, ch, cnt}));
    end
  endtask

  initial begin
    logic [15:0] exp1[8];
    logic [15:0] exp4[4];
    logic [15:0] exp5[6];
    logic [7:0]  ch5[6];
    logic [15:0] cnt5[6];
    logic        last5[6];
    logic [3:0]  pat;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    int          rd_before;
    int          n;

    exp1  = '{16'hC000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001};
    exp4  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    exp5  = '{16'hAAAA, 16'hBBBB, 16'h1234, 16'h5678, 16'h9ABC, 16'hFEED};
    ch5   = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h00};
    cnt5  = '{16'd32, 16'd32, 16'd48, 16'd48, 16'd48, 16'd16};
    last5 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    pat   = 4'b1001;  // out_ready sequence 1,0,0,1 read LSB first

    rst_n          = 1'b0;
    fifo_empty     = 1'b1;
    data_from_fifo = '0;
    gray_mode      = 1'b0;
    out_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_rd_en", 128'(fifo_rd_en), 128'(0));
    check("rst_outs", 128'({out_data, out_ch, out_last, data_count, len_err, busy}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: Gray mode, full length.
    out_ready = 1'b1;
    gray_mode = 1'b1;
    beats.delete();
    push_word(128'h8000_0000_0000_0000_0000_0000_0000_0001, 8'h05, 4'd8);
    drain("t1");
    check("t1_nbeats", 128'(beats.size()), 128'(8));
    for (int i = 0; i < 8; i++) check_beat("t1", i, exp1[i], i == 7, 8'h05, 16'd128);

    // 2: binary pass-through, single beat; out_ch/data_count then hold while idle.
    gray_mode = 1'b0;
    beats.delete();
    push_word(128'hABCD_1234_5678_9ABC_DEF0_1122_3344_5566, 8'h80, 4'd1);
    drain("t2");
    check("t2_nbeats", 128'(beats.size()), 128'(1));
    check_beat("t2", 0, 16'hABCD, 1'b1, 8'h80, 16'd16);
    check("t2_hold", 128'({out_ch, data_count, out_valid}), 128'({8'h80, 16'd16, 1'b0}));

    // 3: illegal lengths 0 and 9 are dropped with one len_err pulse each.
    err_cnt   = 0;
    valid_cnt = 0;
    push_word(128'h1111_1111_1111_1111_1111_1111_1111_1111, 8'h01, 4'd0);
    drain("t3a");
    check("t3_err_a", 128'(err_cnt), 128'(1));
    push_word(128'h2222_2222_2222_2222_2222_2222_2222_2222, 8'h02, 4'd9);
    drain("t3b");
    check("t3_err_b", 128'(err_cnt), 128'(2));
    check("t3_no_valid", 128'(valid_cnt), 128'(0));
    check("t3_idle_hold", 128'({busy, out_ch, data_count}), 128'({1'b0, 8'h80, 16'd16}));

    // 4: stalls on out_ready; gray_mode flips mid-word and must not affect it.
    beats.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    push_word(128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h3C, 4'd4);
    n = 0;
    while ((beats.size() < 4 || busy) && n < 80) begin
      @(posedge clk); #1;
      if (prev_stall) begin
        check("t4_stall", 128'({out_valid, out_data, out_last}),
              128'({1'b1, prev_data, prev_last}));
      end
      if (out_valid) gray_mode = 1'b1;
      out_ready  = pat[n % 4];
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      n++;
    end
    out_ready = 1'b1;
    gray_mode = 1'b0;
    check("t4_done", 128'(n < 80), 128'(1));
    check("t4_nbeats", 128'(beats.size()), 128'(4));
    for (int i = 0; i < 4; i++) check_beat("t4", i, exp4[i], i == 3, 8'h3C, 16'd64);

    // 5: long empty spell, then three back-to-back words.
    beats.delete();
    rd_before = rd_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_pop_empty", 128'(rd_cnt - rd_before), 128'(0));
    rd_times.delete();
    push_word(128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123_4567, 8'h11, 4'd2);
    push_word(128'h1234_5678_9ABC_DEF0_0000_0000_0000_0000, 8'h22, 4'd3);
    push_word(128'hFEED_0000_0000_0000_0000_0000_0000_0000, 8'h00, 4'd1);
    drain("t5");
    check("t5_pops", 128'(rd_cnt - rd_before), 128'(3));
    check("t5_pop_while_empty", 128'(rd_empty_cnt), 128'(0));
    check("t5_nbeats", 128'(beats.size()), 128'(6));
    for (int i = 0; i < 6; i++) check_beat("t5", i, exp5[i], last5[i], ch5[i], cnt5[i]);
    if (rd_times.size() == 3) begin
      // Word interval is nb beats plus three overhead cycles.
      check("t5_gap_ab", 128'(rd_times[1] - rd_times[0]), 128'(5));
      check("t5_gap_bc", 128'(rd_times[2] - rd_times[1]), 128'(6));
    end

    // 6: reset while beat 2 of an 8-beat word is presented.
    beats.delete();
    push_word(128'h0001_0002_0003_0004_0005_0006_0007_0008, 8'h66, 4'd8);
    n = 0;
    while (!(out_valid && out_data == 16'h0003) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach_b2", 128'(n < 50), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs",
          128'({out_valid, out_data, out_ch, out_last, data_count, len_err, busy, fifo_rd_en}),
          128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats.delete();
    @(posedge clk); #1;
    check("t6_quiet", 128'({out_valid, busy}), 128'(0));
    push_word(128'hBEEF_CAFE_0000_0000_0000_0000_0000_0000, 8'h77, 4'd2);
    drain("t6");
    check("t6_nbeats", 128'(beats.size()), 128'(2));
    check_beat("t6", 0, 16'hBEEF, 1'b0, 8'h77, 16'd32);
    check_beat("t6", 1, 16'hCAFE, 1'b1, 8'h77, 16'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
